// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the 7-segment scan path.
//   NUM_DIGITS : number of digits on the display
//   SEG_BLANK  : all segments off (active-low)
//   AN_OFF     : all anodes off (active-low)
//   HEX_SEG    : hex digit -> {g,f,e,d,c,b,a} pattern, active-low, index = nibble
//   state_e    : deghost FSM state (BLANK, DRIVE)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    // Entry 15 (F) is written first, entry 0 last.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational hex nibble to active-low 7-segment pattern.
//   nibble_i [3:0] : hex digit
//   seg_o    [6:0] : {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Drives the active-low anode/segment pins of an 8-digit display from a
// rotating digit select. Every select change is followed by BLANK_CYCLES
// clocks with all anodes off (dead time against ghosting). The display value
// is double-buffered: loads go to a pending buffer that becomes active only on
// a frame boundary (select wrapping 7 -> 0), so a frame is never torn.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   sel [2:0]       : digit select, 0 = rightmost digit
//   value_in [31:0] : eight hex nibbles, nibble i shown on digit i
//   dp_in [7:0]     : decimal points, bit i = 1 lights dp of digit i
//   load            : one-cycle strobe capturing value_in/dp_in into pending
//   an [7:0]        : anode enables, active-low (one-hot-low or all high)
//   seg [6:0]       : segments {g,f,e,d,c,b,a}, active-low
//   dp              : decimal point, active-low
//   frame_done      : one-cycle pulse on each select wrap 7 -> 0
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, digits i>=1 whose nibbles 7..i are
//                           all zero show blank segments (anode and dp still
//                           driven). Undefined: every nibble is decoded.
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    // Load interface: load is a bare strobe with no back-pressure. Every cycle
    // it is high the pending buffer is overwritten, so the last load before a
    // frame boundary is the one that gets displayed.

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        sel_q;
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic              frame_done_q;

    logic [31:0]       active_val_q;
    logic [7:0]        active_dp_q;
    logic [31:0]       pend_val_q;
    logic [7:0]        pend_dp_q;
    logic              pend_valid_q;

    logic              frame_boundary;
    logic [3:0]        cur_nibble;
    logic [6:0]        dec_seg;
    logic [7:0]        lz_blank;
    logic [6:0]        drive_seg_d;
    logic [7:0]        drive_an_d;
    logic              drive_dp_d;

    assign frame_boundary = (sel_q == 3'd7) && (sel == 3'd0);

    // ---------------- display path for the latched select -------------------
    assign cur_nibble = active_val_q[{sel_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Walk from the leftmost digit down; a digit is a leading zero while every
    // nibble at or above it is zero. Digit 0 is never blanked.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (active_val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign drive_seg_d = lz_blank[sel_q] ? SEG_BLANK : dec_seg;
    assign drive_an_d  = ~(8'b1 << sel_q);
    assign drive_dp_d  = ~active_dp_q[sel_q];

    // ---------------- double buffer ------------------------------------------
    // On a boundary the swap reads the old pending contents; a coincident load
    // refills pending for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_val_q <= '0;
            active_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_boundary;
            if (frame_boundary && pend_valid_q) begin
                active_val_q <= pend_val_q;
                active_dp_q  <= pend_dp_q;
            end
            if (load) begin
                pend_val_q   <= value_in;
                pend_dp_q    <= dp_in;
                pend_valid_q <= 1'b1;
            end else if (frame_boundary) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    // ---------------- deghost FSM --------------------------------------------
    // A select change always restarts the blank with cnt=1, so the anodes stay
    // off for the change edge plus BLANK_CYCLES-1 further edges. Out of reset
    // cnt starts at 0, giving one extra blank clock before the first drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else if (sel != sel_q) begin
            sel_q   <= sel;
            state_q <= BLANK;
            cnt_q   <= CNT_W'(1);
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES)) begin
                        state_q <= DRIVE;
                        an_q    <= drive_an_d;
                        seg_q   <= drive_seg_d;
                        dp_q    <= drive_dp_d;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    // Refresh every cycle so a frame swap shows without a
                    // select change.
                    an_q  <= drive_an_d;
                    seg_q <= drive_seg_d;
                    dp_q  <= drive_dp_d;
                end
                default: begin
                    state_q <= BLANK;
                end
            endcase
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed, table-driven bench for seg_scan_driver (BLANK_CYCLES = 4).
// Expected values are hand-decoded from the hex table; digit patterns that
// depend on LEADING_ZERO_BLANK_EN select their expectation with the macro.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int BLANK_CYCLES = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    typedef struct {
        logic [2:0] sel;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  sel;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        load;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs_a[8];
    vec_t vecs_b[8];

    seg_scan_driver #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply a select at a negedge, capture frame_done after the first two
    // edges, and return 1ns after the fifth edge (blank fully elapsed).
    task automatic go_sel(input logic [2:0] s, output logic fd1, output logic fd2);
        @(negedge clk);
        sel = s;
        @(posedge clk); #1 fd1 = frame_done;
        @(posedge clk); #1 fd2 = frame_done;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic [7:0] d);
        @(negedge clk);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_pins(input string tag, input vec_t v);
        check({tag, "_an"},  32'(an),  32'(v.an));
        check({tag, "_seg"}, 32'(seg), 32'(v.seg));
        check({tag, "_dp"},  32'(dp),  32'(v.dp));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic f1, f2;
        int   fd_cnt;

        // value 0123_89AB, dp 01: nibbles B A 9 8 3 2 1 0 on digits 0..7
        vecs_a[0] = '{3'd0, 8'hFE, 7'h03, 1'b0};
        vecs_a[1] = '{3'd1, 8'hFD, 7'h08, 1'b1};
        vecs_a[2] = '{3'd2, 8'hFB, 7'h10, 1'b1};
        vecs_a[3] = '{3'd3, 8'hF7, 7'h00, 1'b1};
        vecs_a[4] = '{3'd4, 8'hEF, 7'h30, 1'b1};
        vecs_a[5] = '{3'd5, 8'hDF, 7'h24, 1'b1};
        vecs_a[6] = '{3'd6, 8'hBF, 7'h79, 1'b1};
        vecs_a[7] = '{3'd7, 8'h7F, LZ_SEG, 1'b1};
        // value 0000_0050, dp 04
        vecs_b[0] = '{3'd0, 8'hFE, 7'h40, 1'b1};
        vecs_b[1] = '{3'd1, 8'hFD, 7'h12, 1'b1};
        vecs_b[2] = '{3'd2, 8'hFB, LZ_SEG, 1'b0};
        vecs_b[3] = '{3'd3, 8'hF7, LZ_SEG, 1'b1};
        vecs_b[4] = '{3'd4, 8'hEF, LZ_SEG, 1'b1};
        vecs_b[5] = '{3'd5, 8'hDF, LZ_SEG, 1'b1};
        vecs_b[6] = '{3'd6, 8'hBF, LZ_SEG, 1'b1};
        vecs_b[7] = '{3'd7, 8'h7F, LZ_SEG, 1'b1};

        rst      = 1'b1;
        sel      = 3'd0;
        value_in = '0;
        dp_in    = '0;
        load     = 1'b0;

        // 1. reset values, then blank then digit 0 of zero value
        repeat (2) @(posedge clk);
        #1;
        check("rst_an",  32'(an),  32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp",  32'(dp),  32'h1);
        check("rst_fd",  32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= BLANK_CYCLES; k++) begin
            @(posedge clk); #1;
            check($sformatf("boot_blank%0d", k), 32'(an), 32'hFF);
        end
        @(posedge clk); #1;
        check_pins("boot_drive", '{3'd0, 8'hFE, 7'h40, 1'b1});

        // 2. load, then a full frame; swap only at the wrap
        pulse_load(32'h0123_89AB, 8'h01);
        @(posedge clk); #1;
        check("load_no_wrap_seg", 32'(seg), 32'h40);
        fd_cnt = 0;
        for (int s = 1; s <= 7; s++) begin
            go_sel(3'(s), f1, f2);
            fd_cnt += int'(f1) + int'(f2);
        end
        check("fd_before_wrap", 32'(fd_cnt), 32'd0);
        go_sel(3'd0, f1, f2);
        check("fd_wrap_pulse", 32'(f1), 32'h1);
        check("fd_wrap_once",  32'(f2), 32'h0);
        for (int i = 0; i < 8; i++) begin
            go_sel(vecs_a[i].sel, f1, f2);
            check_pins($sformatf("frameA_d%0d", i), vecs_a[i]);
        end

        // 3. dead time length, and restart on a mid-blank change
        go_sel(3'd2, f1, f2);
        check("sel2_an", 32'(an), 32'hFB);
        @(negedge clk);
        sel = 3'd5;
        for (int k = 0; k < BLANK_CYCLES; k++) begin
            @(posedge clk); #1;
            check($sformatf("blank25_%0d", k), 32'(an), 32'hFF);
        end
        @(posedge clk); #1;
        check("sel5_an", 32'(an), 32'hDF);
        @(negedge clk);
        sel = 3'd1;
        repeat (2) begin
            @(posedge clk); #1;
            check("blank51", 32'(an), 32'hFF);
        end
        @(negedge clk);
        sel = 3'd6;
        for (int k = 0; k < BLANK_CYCLES; k++) begin
            @(posedge clk); #1;
            check($sformatf("restart_%0d", k), 32'(an), 32'hFF);
        end
        @(posedge clk); #1;
        check("sel6_an", 32'(an), 32'hBF);

        // 4. two loads in one frame: last wins, nothing changes before wrap
        pulse_load(32'h1111_1111, 8'h00);
        pulse_load(32'h2222_2222, 8'h00);
        go_sel(3'd0, f1, f2);
        check("pre_wrap_seg", 32'(seg), 32'h03);
        check("pre_wrap_dp",  32'(dp),  32'h0);
        check("pre_wrap_fd",  32'(f1),  32'h0);
        go_sel(3'd7, f1, f2);
        check("pre_wrap_d7", 32'(seg), 32'(LZ_SEG));
        go_sel(3'd0, f1, f2);
        check("last_load_fd",  32'(f1),  32'h1);
        check("last_load_seg", 32'(seg), 32'h24);
        check("last_load_dp",  32'(dp),  32'h1);
        go_sel(3'd7, f1, f2);
        check("last_load_d7", 32'(seg), 32'h24);

        // load coinciding with the boundary: swap sees empty pending
        @(negedge clk);
        sel      = 3'd0;
        value_in = 32'h0000_0050;
        dp_in    = 8'h04;
        load     = 1'b1;
        @(posedge clk); #1;
        check("coinc_fd", 32'(frame_done), 32'h1);
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("coinc_no_swap_seg", 32'(seg), 32'h24);
        go_sel(3'd7, f1, f2);
        go_sel(3'd0, f1, f2);
        check("coinc_next_fd", 32'(f1), 32'h1);
        for (int i = 0; i < 8; i++) begin
            go_sel(vecs_b[i].sel, f1, f2);
            check_pins($sformatf("frameB_d%0d", i), vecs_b[i]);
        end

        // 5. reset during DRIVE on digit 6, with a pending load outstanding
        go_sel(3'd6, f1, f2);
        check("pre_rst_an", 32'(an), 32'hBF);
        pulse_load(32'h0000_000E, 8'hFF);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sel = 3'd0;
        #1;
        check("async_rst_an",  32'(an),  32'hFF);
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_dp",  32'(dp),  32'h1);
        check("async_rst_fd",  32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (BLANK_CYCLES + 1) @(posedge clk);
        #1;
        check_pins("post_rst", '{3'd0, 8'hFE, 7'h40, 1'b1});
        for (int s = 1; s <= 7; s++) go_sel(3'(s), f1, f2);
        go_sel(3'd0, f1, f2);
        check("post_rst_wrap_fd", 32'(f1), 32'h1);
        check_pins("pending_discarded", '{3'd0, 8'hFE, 7'h40, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
